// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter:
//   owner_t  - which requester owns the memory slot (fetch or load/store)
//   state_t  - arbiter slot state (IDLE, BUSY)
//   MEM_LAT_DEFAULT - default data-memory access latency in cycles
//   LAT_CNT_W - width of the latency down-counter (covers latencies 1..4)
package mem_arb_pkg;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MEM_LAT_DEFAULT = 1;
  localparam int LAT_CNT_W       = 3;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2
// Two-input round-robin chooser. A lone request is always granted; when both
// inputs request, the one that did not win last time is chosen.
// Ports:
//   req[1:0]   in  request vector, bit 0 = fetch port, bit 1 = load/store port
//   last       in  port that won the previous grant
//   grant[1:0] out one-hot grant (same bit order as req), zero if no request
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] grant
);

  // On contention the port that is not 'last' wins, so a reset value of
  // OWN_I for 'last' hands the very first contention to the load/store port.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == OWN_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates a fetch requester (read-only) and a load/store requester onto a
// single-port data memory with a fixed access latency of MEM_LAT cycles.
// Ports:
//   CLK, RST                  clock (rising edge), async active-high reset
//   i_req/i_addr              fetch request
//   i_gnt/i_rvalid/i_rdata    fetch grant and read response
//   d_req/d_we/d_addr/d_be/d_wdata  load/store request
//   d_gnt/d_rvalid/d_rdata    load/store grant and response (write ack too)
//   m_req/m_we/m_addr/m_be/m_wdata/m_rdata  shared data memory port
//   stall_i/stall_d           saturating counts of cycles spent waiting
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [3:0]       d_be,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             m_req,
  output logic             m_we,
  output logic [31:0]      m_addr,
  output logic [3:0]       m_be,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,
  output logic [CNT_W-1:0] stall_i,
  output logic [CNT_W-1:0] stall_d
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  state_t               state, state_nxt;
  owner_t               owner, owner_nxt;
  owner_t               last_owner, last_nxt;
  logic [LAT_CNT_W-1:0] cnt, cnt_nxt;

  logic       slot_open;
  logic       resp_cycle;
  logic [1:0] req_vec;
  logic [1:0] grant;

  // A new grant may be issued when idle or in the final cycle of the current
  // access, which is what gives back-to-back throughput. Both qualifiers are
  // gated by RST so nothing is granted or acknowledged while reset is high,
  // including the first cycle, before the async reset has been sampled.
  assign slot_open  = !RST && ((state == IDLE) || (cnt == CNT_ONE));
  assign resp_cycle = !RST && (state == BUSY) && (cnt == CNT_ONE);
  assign req_vec    = {d_req, i_req} & {2{slot_open}};

  arb_rr2 u_rr (
    .req   (req_vec),
    .last  (last_owner),
    .grant (grant)
  );

  // Slot state, owner, round-robin history and latency counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_I;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Grant decode, memory port mux and next-state logic. The memory port is
  // only active in the grant cycle; fetches are always full-word reads with
  // the byte offset dropped from the address.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last_owner;
    cnt_nxt   = cnt;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'h0;
    m_be      = 4'h0;
    m_wdata   = 32'h0;

    if (grant[1]) begin
      d_gnt     = 1'b1;
      m_req     = 1'b1;
      m_we      = d_we;
      m_addr    = {d_addr[31:2], 2'b00};
      m_be      = d_be;
      m_wdata   = d_wdata;
      owner_nxt = OWN_D;
      last_nxt  = OWN_D;
      cnt_nxt   = LAT_LOAD;
      state_nxt = BUSY;
    end else if (grant[0]) begin
      i_gnt     = 1'b1;
      m_req     = 1'b1;
      m_addr    = {i_addr[31:2], 2'b00};
      m_be      = 4'hF;
      owner_nxt = OWN_I;
      last_nxt  = OWN_I;
      cnt_nxt   = LAT_LOAD;
      state_nxt = BUSY;
    end else if (state == BUSY) begin
      if (cnt == CNT_ONE) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - CNT_ONE;
      end
    end
  end

  // Response steering: only the current owner sees rvalid, and rdata is held
  // at zero whenever its rvalid is low.
  always_comb begin
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = 32'h0;
    d_rdata  = 32'h0;
    if (resp_cycle) begin
      if (owner == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end else begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end
    end
  end

  // Wait-cycle counters: count every cycle a request is pending but not
  // granted, and stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_i <= '0;
      stall_d <= '0;
    end else begin
      if (i_req && !i_gnt && (stall_i != '1)) begin
        stall_i <= stall_i + CNT_W'(1);
      end
      if (d_req && !d_gnt && (stall_d != '1)) begin
        stall_d <= stall_d + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances share one clock:
//   instance 0: MEM_LAT=1  (reset, single load, alternation, saturation)
//   instance 1: MEM_LAT=3  (store with byte enables, fetch withdrawn)
//   instance 2: MEM_LAT=2  (reset during an in-flight fetch)
// All use CNT_W=4 so counter saturation is reachable in a few dozen cycles.
module tb_mem_arbiter;

  logic        clk;
  logic        rst      [3];
  logic        i_req    [3];
  logic [31:0] i_addr   [3];
  logic        i_gnt    [3];
  logic        i_rvalid [3];
  logic [31:0] i_rdata  [3];
  logic        d_req    [3];
  logic        d_we     [3];
  logic [31:0] d_addr   [3];
  logic [3:0]  d_be     [3];
  logic [31:0] d_wdata  [3];
  logic        d_gnt    [3];
  logic        d_rvalid [3];
  logic [31:0] d_rdata  [3];
  logic        m_req    [3];
  logic        m_we     [3];
  logic [31:0] m_addr   [3];
  logic [3:0]  m_be     [3];
  logic [31:0] m_wdata  [3];
  logic [31:0] m_rdata  [3];
  logic [3:0]  stall_i  [3];
  logic [3:0]  stall_d  [3];

  int tests_run;
  int tests_failed;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(
      .MEM_LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
      .CNT_W   (4)
    ) dut (
      .CLK      (clk),
      .RST      (rst[g]),
      .i_req    (i_req[g]),
      .i_addr   (i_addr[g]),
      .i_gnt    (i_gnt[g]),
      .i_rvalid (i_rvalid[g]),
      .i_rdata  (i_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_be     (d_be[g]),
      .d_wdata  (d_wdata[g]),
      .d_gnt    (d_gnt[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .m_req    (m_req[g]),
      .m_we     (m_we[g]),
      .m_addr   (m_addr[g]),
      .m_be     (m_be[g]),
      .m_wdata  (m_wdata[g]),
      .m_rdata  (m_rdata[g]),
      .stall_i  (stall_i[g]),
      .stall_d  (stall_d[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled one
  // more unit later, well away from the next edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    next_cycle();
    i_req[0] = 1'b1;
    d_req[0] = 1'b1;
    #1;
    tests_run++;
    if (i_gnt[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_i_gnt: got %b expected 0", i_gnt[0]);
    end
    tests_run++;
    if (d_gnt[0] !== 1'b0 || m_req[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_d_gnt_m_req: got %b/%b expected 0/0", d_gnt[0], m_req[0]);
    end
    tests_run++;
    if (i_rvalid[0] !== 1'b0 || d_rvalid[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rvalid: got %b/%b expected 0/0", i_rvalid[0], d_rvalid[0]);
    end
    next_cycle();
    #1;
    tests_run++;
    if (stall_i[0] !== 4'd0 || stall_d[0] !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_stall: got %0d/%0d expected 0/0", stall_i[0], stall_d[0]);
    end
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
  endtask

  task automatic test_single_load();
    next_cycle();
    rst[0]    = 1'b0;
    d_req[0]  = 1'b1;
    d_we[0]   = 1'b0;
    d_addr[0] = 32'h0000_0106;
    d_be[0]   = 4'hF;
    #1;
    tests_run++;
    if (d_gnt[0] !== 1'b1 || i_gnt[0] !== 1'b0 || m_req[0] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL load_gnt: got d_gnt=%b i_gnt=%b m_req=%b expected 1/0/1", d_gnt[0], i_gnt[0], m_req[0]);
    end
    tests_run++;
    if (m_addr[0] !== 32'h0000_0104 || m_we[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_addr: got %h we=%b expected 00000104 we=0", m_addr[0], m_we[0]);
    end
    next_cycle();
    d_req[0]   = 1'b0;
    m_rdata[0] = 32'h1234_5678;
    #1;
    tests_run++;
    if (d_rvalid[0] !== 1'b1 || d_rdata[0] !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL load_resp: got rvalid=%b rdata=%h expected 1 12345678", d_rvalid[0], d_rdata[0]);
    end
    tests_run++;
    if (i_rvalid[0] !== 1'b0 || i_rdata[0] !== 32'h0 || m_req[0] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL load_nonowner: got i_rvalid=%b i_rdata=%h m_req=%b expected 0 0 0", i_rvalid[0], i_rdata[0], m_req[0]);
    end
    next_cycle();
    #1;
    tests_run++;
    if (d_rvalid[0] !== 1'b0 || d_rdata[0] !== 32'h0 || stall_d[0] !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL load_after: got rvalid=%b rdata=%h stall_d=%0d expected 0 0 0", d_rvalid[0], d_rdata[0], stall_d[0]);
    end
  endtask

  // Both requesters held from inside reset: D wins first, then strict
  // alternation with back-to-back grants, and each denied cycle is counted.
  task automatic test_alternate();
    next_cycle();
    rst[0]     = 1'b1;
    i_req[0]   = 1'b1;
    i_addr[0]  = 32'h0000_1003;
    d_req[0]   = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h0000_2002;
    d_be[0]    = 4'h5;
    d_wdata[0] = 32'hAAAA_5555;
    m_rdata[0] = 32'h0BAD_F00D;
    next_cycle();
    rst[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (k % 2 == 1) begin
        tests_run++;
        if (d_gnt[0] !== 1'b1 || i_gnt[0] !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL alt_gnt_d cycle %0d: got d=%b i=%b expected d=1 i=0", k, d_gnt[0], i_gnt[0]);
        end
        tests_run++;
        if (m_addr[0] !== 32'h0000_2000 || m_we[0] !== 1'b1 || m_be[0] !== 4'h5 || m_wdata[0] !== 32'hAAAA_5555) begin
          tests_failed++;
          $display("[TB] FAIL alt_mem_d cycle %0d: got %h %b %h %h expected 00002000 1 5 aaaa5555", k, m_addr[0], m_we[0], m_be[0], m_wdata[0]);
        end
      end else begin
        tests_run++;
        if (i_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL alt_gnt_i cycle %0d: got i=%b d=%b expected i=1 d=0", k, i_gnt[0], d_gnt[0]);
        end
        tests_run++;
        if (m_addr[0] !== 32'h0000_1000 || m_we[0] !== 1'b0 || m_be[0] !== 4'hF || m_wdata[0] !== 32'h0) begin
          tests_failed++;
          $display("[TB] FAIL alt_mem_i cycle %0d: got %h %b %h %h expected 00001000 0 f 0", k, m_addr[0], m_we[0], m_be[0], m_wdata[0]);
        end
      end
      tests_run++;
      if (stall_i[0] !== 4'(k / 2) || stall_d[0] !== 4'((k - 1) / 2)) begin
        tests_failed++;
        $display("[TB] FAIL alt_stall cycle %0d: got %0d/%0d expected %0d/%0d", k, stall_i[0], stall_d[0], k / 2, (k - 1) / 2);
      end
      if (k > 1) begin
        tests_run++;
        if (i_rvalid[0] !== (k % 2 == 1) || d_rvalid[0] !== (k % 2 == 0)) begin
          tests_failed++;
          $display("[TB] FAIL alt_rvalid cycle %0d: got i=%b d=%b expected i=%b d=%b", k, i_rvalid[0], d_rvalid[0], k % 2 == 1, k % 2 == 0);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Continues the alternation until both 4-bit counters pass all-ones.
  task automatic test_saturation();
    for (int k = 0; k < 32; k++) begin
      next_cycle();
    end
    #1;
    tests_run++;
    if (stall_i[0] !== 4'hF || stall_d[0] !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL sat_reach: got %h/%h expected f/f", stall_i[0], stall_d[0]);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
    end
    #1;
    tests_run++;
    if (stall_i[0] !== 4'hF || stall_d[0] !== 4'hF) begin
      tests_failed++;
      $display("[TB] FAIL sat_hold: got %h/%h expected f/f", stall_i[0], stall_d[0]);
    end
    i_req[0] = 1'b0;
    d_req[0] = 1'b0;
  endtask

  // MEM_LAT=3: store wins contention, fetch waits two cycles then withdraws.
  task automatic test_store_withdraw();
    next_cycle();
    rst[1]     = 1'b0;
    d_req[1]   = 1'b1;
    d_we[1]    = 1'b1;
    d_addr[1]  = 32'h0000_0040;
    d_be[1]    = 4'b0011;
    d_wdata[1] = 32'hDEAD_BEEF;
    i_req[1]   = 1'b1;
    i_addr[1]  = 32'h0000_0080;
    m_rdata[1] = 32'hFEED_0001;
    #1;
    tests_run++;
    if (d_gnt[1] !== 1'b1 || i_gnt[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL st_gnt: got d=%b i=%b expected d=1 i=0", d_gnt[1], i_gnt[1]);
    end
    tests_run++;
    if (m_req[1] !== 1'b1 || m_we[1] !== 1'b1 || m_be[1] !== 4'b0011 || m_wdata[1] !== 32'hDEAD_BEEF || m_addr[1] !== 32'h0000_0040) begin
      tests_failed++;
      $display("[TB] FAIL st_mem: got req=%b we=%b be=%b wdata=%h addr=%h", m_req[1], m_we[1], m_be[1], m_wdata[1], m_addr[1]);
    end
    next_cycle();
    d_req[1] = 1'b0;
    #1;
    tests_run++;
    if (m_req[1] !== 1'b0 || m_we[1] !== 1'b0 || m_be[1] !== 4'h0 || d_rvalid[1] !== 1'b0 || i_gnt[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL st_busy1: got m_req=%b m_we=%b m_be=%h d_rvalid=%b i_gnt=%b expected all 0", m_req[1], m_we[1], m_be[1], d_rvalid[1], i_gnt[1]);
    end
    next_cycle();
    i_req[1] = 1'b0;
    #1;
    tests_run++;
    if (m_req[1] !== 1'b0 || d_rvalid[1] !== 1'b0 || i_gnt[1] !== 1'b0 || stall_i[1] !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL st_busy2: got m_req=%b d_rvalid=%b i_gnt=%b stall_i=%0d expected 0 0 0 2", m_req[1], d_rvalid[1], i_gnt[1], stall_i[1]);
    end
    next_cycle();
    #1;
    tests_run++;
    if (d_rvalid[1] !== 1'b1 || d_rdata[1] !== 32'hFEED_0001 || i_rvalid[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL st_ack: got d_rvalid=%b d_rdata=%h i_rvalid=%b expected 1 feed0001 0", d_rvalid[1], d_rdata[1], i_rvalid[1]);
    end
    tests_run++;
    if (i_gnt[1] !== 1'b0 || m_req[1] !== 1'b0 || stall_i[1] !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL st_withdrawn: got i_gnt=%b m_req=%b stall_i=%0d expected 0 0 2", i_gnt[1], m_req[1], stall_i[1]);
    end
    next_cycle();
    #1;
    tests_run++;
    if (d_rvalid[1] !== 1'b0 || i_rvalid[1] !== 1'b0 || m_req[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL st_idle: got d_rvalid=%b i_rvalid=%b m_req=%b expected 0 0 0", d_rvalid[1], i_rvalid[1], m_req[1]);
    end
  endtask

  // MEM_LAT=2: reset lands one cycle after a fetch grant and kills it.
  task automatic test_reset_midflight();
    next_cycle();
    rst[2]     = 1'b0;
    i_req[2]   = 1'b1;
    i_addr[2]  = 32'h0000_0014;
    m_rdata[2] = 32'h55AA_55AA;
    #1;
    tests_run++;
    if (i_gnt[2] !== 1'b1 || m_addr[2] !== 32'h0000_0014) begin
      tests_failed++;
      $display("[TB] FAIL mf_gnt: got i_gnt=%b m_addr=%h expected 1 00000014", i_gnt[2], m_addr[2]);
    end
    next_cycle();
    i_req[2] = 1'b0;
    #1;
    tests_run++;
    if (i_rvalid[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mf_early_rvalid: got %b expected 0", i_rvalid[2]);
    end
    rst[2]   = 1'b1;
    i_req[2] = 1'b1;
    #1;
    tests_run++;
    if (i_rvalid[2] !== 1'b0 || i_gnt[2] !== 1'b0 || m_req[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mf_in_reset: got rvalid=%b gnt=%b m_req=%b expected 0 0 0", i_rvalid[2], i_gnt[2], m_req[2]);
    end
    next_cycle();
    rst[2]   = 1'b0;
    i_req[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (i_rvalid[2] !== 1'b0 || stall_i[2] !== 4'd0 || stall_d[2] !== 4'd0) begin
        tests_failed++;
        $display("[TB] FAIL mf_after cycle %0d: got rvalid=%b stall=%0d/%0d expected 0 0/0", k, i_rvalid[2], stall_i[2], stall_d[2]);
      end
      next_cycle();
    end
    d_req[2]  = 1'b1;
    d_we[2]   = 1'b0;
    d_addr[2] = 32'h0000_0020;
    d_be[2]   = 4'hF;
    #1;
    tests_run++;
    if (d_gnt[2] !== 1'b1 || m_req[2] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mf_regrant: got d_gnt=%b m_req=%b expected 1 1", d_gnt[2], m_req[2]);
    end
    next_cycle();
    d_req[2] = 1'b0;
    #1;
    tests_run++;
    if (d_rvalid[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mf_regrant_early: got %b expected 0", d_rvalid[2]);
    end
    next_cycle();
    #1;
    tests_run++;
    if (d_rvalid[2] !== 1'b1 || d_rdata[2] !== 32'h55AA_55AA || i_rvalid[2] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mf_regrant_resp: got d_rvalid=%b d_rdata=%h i_rvalid=%b expected 1 55aa55aa 0", d_rvalid[2], d_rdata[2], i_rvalid[2]);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int g = 0; g < 3; g++) begin
      rst[g]     = 1'b1;
      i_req[g]   = 1'b0;
      i_addr[g]  = 32'h0;
      d_req[g]   = 1'b0;
      d_we[g]    = 1'b0;
      d_addr[g]  = 32'h0;
      d_be[g]    = 4'h0;
      d_wdata[g] = 32'h0;
      m_rdata[g] = 32'h0;
    end
    test_reset();
    test_single_load();
    test_alternate();
    test_saturation();
    test_store_withdraw();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning data-memory access latency in cycles (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the per-port stall counters.
REQ-003 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_req in 1, i_addr in 32, i_gnt out 1, i_rvalid out 1, i_rdata out 32  fetch requester (read-only).
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_be in 4, d_wdata in 32, d_gnt out 1, d_rvalid out 1, d_rdata out 32  load/store requester.
REQ-007 SHALL have ports m_req out 1, m_we out 1, m_addr out 32, m_be out 4, m_wdata out 32, m_rdata in 32  shared single-port data memory.
REQ-008 SHALL have ports stall_i out CNT_W, stall_d out CNT_W  saturating wait-cycle counters.

Function
REQ-009 SHALL implement FSM states IDLE and BUSY plus registers owner (I/D), down-counter cnt, and last_owner.
REQ-010 SHALL, in IDLE or in BUSY with cnt==1, grant at most one pending request in that cycle: assert that port's gnt for one cycle and m_req in the same cycle, combinationally.
REQ-011 SHALL, on a grant, latch owner, load cnt=MEM_LAT, and enter or stay in BUSY; otherwise, when cnt==1, return to IDLE.
REQ-012 SHALL, with a single requester pending, grant it; with both pending, grant the port not equal to last_owner, then set last_owner to the granted port.
REQ-013 SHALL drive m_addr={addr[31:2],2'b00} from the granted port; for I: m_we=0, m_be=4'hF, m_wdata=0; for D: d_we, d_be, d_wdata pass through.
REQ-014 SHALL drive m_req=0, m_we=0, m_be=0 when no grant is issued.
REQ-015 SHALL assert owner's rvalid for exactly one cycle in the BUSY cycle with cnt==1 (MEM_LAT cycles after grant), with rdata=m_rdata; for a write, rvalid is the write-completion ack.
REQ-016 SHALL drive the non-owner's rvalid to 0 and both rdata outputs to 0 when their rvalid is 0.
REQ-017 SHALL sustain one transaction per MEM_LAT cycles (back-to-back grant in the response cycle).
REQ-018 SHALL require requesters to hold req/addr/we/be/wdata stable until gnt; withdrawing req before gnt SHALL cancel the request with no side effects.
REQ-019 SHALL perform d_we=1 with d_be=0 as a normal transaction (no bytes written, ack returned).
REQ-020 SHALL increment stall_i (stall_d) each cycle that i_req (d_req) is high and i_gnt (d_gnt) is low, saturating at all-ones.

Reset
REQ-021 SHALL, on RST, immediately force state=IDLE, cnt=0, owner=I, last_owner=I (first contention goes to D), stall counters=0, and all gnt/rvalid/m_req outputs low.
REQ-022 SHALL, on RST mid-transaction, drop the in-flight response; no rvalid for it after reset release.
REQ-023 SHALL issue no grant in the first cycle RST is high, and may grant in the first cycle after release.

Structure
REQ-024 SHALL place owner enum (OWN_I, OWN_D), state enum (IDLE, BUSY), and MEM_LAT default in shared package mem_arb_pkg.
REQ-025 SHALL factor the two-input round-robin choice (REQ-012) into sub-module arb_rr2 (inputs req[1:0], last; output grant one-hot).

Verification
REQ-026 SHALL cover: MEM_LAT=1, d_req load addr 0x0000_0106 alone -> d_gnt same cycle, m_addr=0x0000_0104, d_rvalid next cycle with d_rdata=m_rdata.
REQ-027 SHALL cover: both req held continuously from reset -> grants alternate D,I,D,I; stall_i/stall_d each increment on every denied cycle.
REQ-028 SHALL cover: MEM_LAT=3, store d_be=4'b0011 d_wdata=0xDEADBEEF -> m_we=1, m_be=0011 for one cycle, d_rvalid exactly 3 cycles later, no i_rvalid.
REQ-029 SHALL cover: RST asserted one cycle after an I grant (MEM_LAT=2) -> no i_rvalid ever, counters 0, next request granted normally.
REQ-030 SHALL cover: i_req withdrawn while D busy -> no i_gnt, no memory access for I; stall counter forced to all-ones stays saturated.
